// File: rtl/ifd_decode_scoreboard.sv
// rtl/ifd_decode_scoreboard.sv - PDP-8 fetch/decode scoreboard: pairs fetched words with decoded opcodes.
// Optional full op7 word check: define IFD_OP7_DECODE_CHK_EN.
module ifd_decode_scoreboard #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4,
  parameter int RD_LAT     = 1,
  parameter int TIMEOUT    = 64,
  parameter int ERR_W      = 16,
  parameter logic [ADDR_WIDTH-1:0] START_ADDRESS = ADDR_WIDTH'('o200)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ifu_rd_req,
  input  logic [DATA_WIDTH-1:0]  ifu_rd_data,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [5:0]             mem_op,
  input  logic [DATA_WIDTH-4:0]  mem_addr,
  input  logic [21:0]            op7_op,
  input  logic                   stall,
  output logic                   err_pulse,
  output logic [2:0]             err_code,
  output logic [ERR_W-1:0]       err_count,
  output logic                   first_err_vld,
  output logic [2:0]             first_err_code,
  output logic [DATA_WIDTH-1:0]  first_err_data,
  output logic [27:0]            cov_seen,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AGE_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [AGE_W-1:0] AGE_LIM  = AGE_W'(TIMEOUT - 1);
  localparam logic [2:0] OPC_IOT = 3'b110;
  localparam logic [2:0] OPC_OP7 = 3'b111;

  logic                  req_q;
  logic                  dec_q;
  logic [RD_LAT-1:0]     dly_q, dly_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [AGE_W-1:0]      age_q, age_d;
  logic                  first_decode_q, first_decode_d;
  logic                  err_pulse_q, err_pulse_d;
  logic [2:0]            err_code_q, err_code_d;
  logic [ERR_W-1:0]      err_count_q, err_count_d;
  logic                  first_err_vld_q, first_err_vld_d;
  logic [2:0]            first_err_code_q, first_err_code_d;
  logic [DATA_WIDTH-1:0] first_err_data_q, first_err_data_d;
  logic [27:0]           cov_q, cov_d;

  logic                  req_rise, dec_lvl, dec_rise;
  logic                  fifo_empty, fifo_full;
  logic [DATA_WIDTH-1:0] head_word;
  logic [2:0]            head_opc;
  logic                  push_evt, push_ok, pop_dec, pop;
  logic                  onehot, dec_ok, op7_word_ok;
  logic                  e_illegal, e_mismatch, e_notclr, e_overflow;
  logic                  e_timeout, e_orphan, e_start;
  logic [6:0]            err_vec;
  logic                  err_any;

  function automatic logic [2:0] mem_index(input logic [5:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  assign head_word = mem_q[rd_ptr_q];
  assign head_opc  = head_word[DATA_WIDTH-1 -: 3];

`ifdef IFD_OP7_DECODE_CHK_EN
  localparam logic [11:0] OP7_ENC [22] = '{
    12'o7000, 12'o7001, 12'o7002, 12'o7004, 12'o7006, 12'o7010, 12'o7012, 12'o7020,
    12'o7040, 12'o7041, 12'o7100, 12'o7200, 12'o7402, 12'o7404, 12'o7410, 12'o7420,
    12'o7430, 12'o7440, 12'o7450, 12'o7500, 12'o7510, 12'o7600};

  // Bit 0 (NOP) is skipped: any group-7 word is an acceptable NOP.
  always_comb begin
    op7_word_ok = 1'b1;
    for (int i = 1; i < 22; i++) begin
      if (op7_op[i] && (head_word != DATA_WIDTH'(OP7_ENC[i]))) op7_word_ok = 1'b0;
    end
  end
`else
  assign op7_word_ok = 1'b1;
`endif

  always_comb begin
    req_rise   = ifu_rd_req & ~req_q;
    dec_lvl    = (|mem_op) | (|op7_op);
    dec_rise   = dec_lvl & ~dec_q;
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == FULL_CNT);
    onehot     = ($countones({op7_op, mem_op}) == 1);

    dly_d    = '0;
    dly_d[0] = req_rise;
    for (int i = 1; i < RD_LAT; i++) begin
      dly_d[i] = dly_q[i-1];
    end
    // IOT words never reach the decoder, so they are not expected there.
    push_evt = dly_q[RD_LAT-1] & (ifu_rd_data[DATA_WIDTH-1 -: 3] != OPC_IOT);

    if (|mem_op) begin
      dec_ok = (head_opc == mem_index(mem_op)) && (head_word[DATA_WIDTH-4:0] == mem_addr);
    end else begin
      dec_ok = (head_opc == OPC_OP7) && op7_word_ok;
    end

    pop_dec    = dec_rise & ~fifo_empty;
    e_orphan   = dec_rise & fifo_empty;
    e_illegal  = pop_dec & ~onehot;
    e_mismatch = pop_dec & onehot & ~dec_ok;
    e_start    = dec_rise & first_decode_q & (base_addr != START_ADDRESS);
    e_notclr   = req_rise & dec_lvl;
    e_timeout  = ~fifo_empty & ~stall & ~pop_dec & (age_q == AGE_LIM);
    pop        = pop_dec | e_timeout;
    // A pop in the same cycle frees the slot the push needs.
    push_ok    = push_evt & (~fifo_full | pop);
    e_overflow = push_evt & fifo_full & ~pop;

    err_vec = {e_start, e_orphan, e_timeout, e_overflow, e_notclr, e_mismatch, e_illegal};
    err_any = |err_vec;

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    if (fifo_empty || pop) begin
      age_d = '0;
    end else if (!stall) begin
      age_d = age_q + AGE_W'(1);
    end else begin
      age_d = age_q;
    end

    first_decode_d = first_decode_q & ~dec_rise;

    err_pulse_d = err_any;
    err_code_d  = 3'd0;
    for (int k = 6; k >= 0; k--) begin
      if (err_vec[k]) err_code_d = 3'(k + 1);
    end

    err_count_d = err_count_q;
    if (err_any && !(&err_count_q)) err_count_d = err_count_q + ERR_W'(1);

    first_err_vld_d  = first_err_vld_q;
    first_err_code_d = first_err_code_q;
    first_err_data_d = first_err_data_q;
    if (err_any && !first_err_vld_q) begin
      first_err_vld_d  = 1'b1;
      first_err_code_d = err_code_d;
      first_err_data_d = fifo_empty ? '0 : head_word;
    end

    cov_d = cov_q;
    if (dec_rise && onehot) cov_d = cov_q | {op7_op, mem_op};
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= ifu_rd_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q            <= 1'b0;
      dec_q            <= 1'b0;
      dly_q            <= '0;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      cnt_q            <= '0;
      age_q            <= '0;
      first_decode_q   <= 1'b1;
      err_pulse_q      <= 1'b0;
      err_code_q       <= 3'd0;
      err_count_q      <= '0;
      first_err_vld_q  <= 1'b0;
      first_err_code_q <= 3'd0;
      first_err_data_q <= '0;
      cov_q            <= '0;
    end else begin
      req_q            <= ifu_rd_req;
      dec_q            <= dec_lvl;
      dly_q            <= dly_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      cnt_q            <= cnt_d;
      age_q            <= age_d;
      first_decode_q   <= first_decode_d;
      err_pulse_q      <= err_pulse_d;
      err_code_q       <= err_code_d;
      err_count_q      <= err_count_d;
      first_err_vld_q  <= first_err_vld_d;
      first_err_code_q <= first_err_code_d;
      first_err_data_q <= first_err_data_d;
      cov_q            <= cov_d;
    end
  end

  assign err_pulse      = err_pulse_q;
  assign err_code       = err_code_q;
  assign err_count      = err_count_q;
  assign first_err_vld  = first_err_vld_q;
  assign first_err_code = first_err_code_q;
  assign first_err_data = first_err_data_q;
  assign cov_seen       = cov_q;
  assign fifo_level     = cnt_q;

endmodule

// File: tb/tb_ifd_decode_scoreboard.sv
// tb/tb_ifd_decode_scoreboard.sv - self-checking bench for ifd_decode_scoreboard with a queue-based model.
module tb_ifd_decode_scoreboard;

  localparam int DW      = 12;
  localparam int AW      = 12;
  localparam int DEPTH   = 4;
  localparam int RD_LAT  = 1;
  localparam int TIMEOUT = 64;
  localparam int ERR_W   = 4;
  localparam logic [11:0] START = 12'o200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ifu_rd_req, stall;
  logic [11:0] ifu_rd_data, base_addr;
  logic [5:0]  mem_op;
  logic [8:0]  mem_addr;
  logic [21:0] op7_op;
  logic        err_pulse, first_err_vld;
  logic [2:0]  err_code, first_err_code;
  logic [ERR_W-1:0] err_count;
  logic [11:0] first_err_data;
  logic [27:0] cov_seen;
  logic [2:0]  fifo_level;

  ifd_decode_scoreboard #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RD_LAT(RD_LAT),
    .TIMEOUT(TIMEOUT), .ERR_W(ERR_W), .START_ADDRESS(START)
  ) dut (
    .clk(clk), .reset(reset), .ifu_rd_req(ifu_rd_req), .ifu_rd_data(ifu_rd_data),
    .base_addr(base_addr), .mem_op(mem_op), .mem_addr(mem_addr), .op7_op(op7_op),
    .stall(stall), .err_pulse(err_pulse), .err_code(err_code), .err_count(err_count),
    .first_err_vld(first_err_vld), .first_err_code(first_err_code),
    .first_err_data(first_err_data), .cov_seen(cov_seen), .fifo_level(fifo_level)
  );

  logic [11:0] q[$];
  int          due[$];
  int          cyc = 0;
  int          waited;
  bit          prev_req, prev_dec, first_dec;
  bit          x_pulse, x_fvld;
  logic [2:0]  x_code, x_fcode;
  int          x_count;
  logic [11:0] x_fdata;
  logic [27:0] x_cov;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] idx_of(input logic [5:0] v);
    for (int k = 0; k < 6; k++) begin
      if (v == 6'(1 << k)) return 3'(k);
    end
    return 3'd0;
  endfunction

  task automatic model_step();
    bit          rr, dr, lvl, push_w, was_empty, popd, tmo, onehot, ok;
    bit [7:1]    e;
    logic [11:0] head;
    cyc++;
    if (reset) begin
      q.delete(); due.delete();
      waited = 0; prev_req = 0; prev_dec = 0; first_dec = 1;
      x_pulse = 0; x_code = 0; x_count = 0; x_fvld = 0; x_fcode = 0; x_fdata = 0; x_cov = 0;
      return;
    end
    e      = '0;
    lvl    = (mem_op != 0) || (op7_op != 0);
    rr     = ifu_rd_req && !prev_req;
    dr     = lvl && !prev_dec;
    prev_req = ifu_rd_req;
    prev_dec = lvl;
    push_w = 0;
    if (due.size() > 0 && due[0] == cyc) begin
      void'(due.pop_front());
      push_w = (ifu_rd_data[11:9] != 3'b110);
    end
    if (rr) due.push_back(cyc + RD_LAT);
    was_empty = (q.size() == 0);
    head      = was_empty ? 12'h000 : q[0];
    onehot    = ($countones({op7_op, mem_op}) == 1);
    if (rr && lvl) e[3] = 1;
    popd = 0;
    if (dr) begin
      if (was_empty) e[6] = 1;
      else begin
        popd = 1;
        if (!onehot) e[1] = 1;
        else begin
          if (mem_op != 0) ok = (head[11:9] == idx_of(mem_op)) && (head[8:0] == mem_addr);
          else ok = (head[11:9] == 3'b111);
          if (!ok) e[2] = 1;
        end
      end
      if (first_dec && base_addr != START) e[7] = 1;
      first_dec = 0;
      if (onehot) x_cov = x_cov | {op7_op, mem_op};
    end
    tmo = !was_empty && !popd && !stall && (waited + 1 >= TIMEOUT);
    if (tmo) e[5] = 1;
    if (popd || tmo) begin
      void'(q.pop_front());
      waited = 0;
    end else if (!was_empty && !stall) begin
      waited++;
    end
    if (push_w) begin
      if (q.size() >= DEPTH) e[4] = 1;
      else q.push_back(ifu_rd_data);
    end
    x_pulse = (e != 0);
    x_code  = 3'd0;
    for (int k = 7; k >= 1; k--) begin
      if (e[k]) x_code = 3'(k);
    end
    if (x_pulse) begin
      if (x_count < (1 << ERR_W) - 1) x_count++;
      if (!x_fvld) begin
        x_fvld = 1; x_fcode = x_code; x_fdata = head;
      end
    end
  endtask

  task automatic compare_all();
    check("err_pulse", 32'(err_pulse), 32'(x_pulse));
    if (x_pulse) check("err_code", 32'(err_code), 32'(x_code));
    check("err_count", 32'(err_count), 32'(x_count));
    check("first_err_vld", 32'(first_err_vld), 32'(x_fvld));
    check("first_err_code", 32'(first_err_code), 32'(x_fcode));
    check("first_err_data", 32'(first_err_data), 32'(x_fdata));
    check("cov_seen", 32'(cov_seen), 32'(x_cov));
    check("fifo_level", 32'(fifo_level), 32'(q.size()));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_dec(input logic [5:0] m, input logic [8:0] a, input logic [21:0] o);
    mem_op = m; mem_addr = a; op7_op = o;
  endtask

  task automatic fetch(input logic [11:0] w);
    ifu_rd_req = 1'b1;
    cycle();
    ifu_rd_req = 1'b0;
    for (int i = 1; i < RD_LAT; i++) cycle();
    ifu_rd_data = w;
    cycle();
    ifu_rd_data = 12'h000;
  endtask

  task automatic do_reset();
    reset = 1'b1; ifu_rd_req = 1'b0; ifu_rd_data = 12'h000; stall = 1'b0;
    set_dec(6'd0, 9'd0, 22'd0);
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    logic [11:0] w;
    logic [5:0]  m;
    logic [21:0] o;
    int          r;
    base_addr = START;
    do_reset();
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_cov", 32'(cov_seen), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);

    fetch(12'o1205);
    check("tp1_level_push", 32'(fifo_level), 32'd1);
    set_dec(6'b000010, 9'o205, 22'd0);
    cycle();
    check("tp1_pulse", 32'(err_pulse), 32'd0);
    check("tp1_cov1", 32'(cov_seen[1]), 32'd1);
    check("tp1_level", 32'(fifo_level), 32'd0);
    set_dec(6'd0, 9'd0, 22'd0);
    cycle();

    fetch(12'o3010);
    set_dec(6'b000001, 9'o010, 22'd0);
    cycle();
    check("tp2_pulse", 32'(err_pulse), 32'd1);
    check("tp2_code", 32'(err_code), 32'd2);
    check("tp2_fdata", 32'(first_err_data), 32'(12'o3010));
    check("tp2_count", 32'(err_count), 32'd1);
    set_dec(6'd0, 9'd0, 22'd0);
    cycle();

    fetch(12'o7001);
    set_dec(6'd0, 9'd0, 22'b110);
    cycle();
    check("tp3_code", 32'(err_code), 32'd1);
    set_dec(6'd0, 9'd0, 22'd0);
    cycle();

    for (int i = 0; i < 5; i++) fetch(12'o1000 + 12'(i));
    check("tp4_pulse", 32'(err_pulse), 32'd1);
    check("tp4_code", 32'(err_code), 32'd4);
    check("tp4_level", 32'(fifo_level), 32'd4);

    do_reset();
    fetch(12'o1111);
    repeat (TIMEOUT - 1) cycle();
    check("tp5_early", 32'(err_pulse), 32'd0);
    cycle();
    check("tp5_pulse", 32'(err_pulse), 32'd1);
    check("tp5_code", 32'(err_code), 32'd5);
    check("tp5_level", 32'(fifo_level), 32'd0);
    stall = 1'b1;
    fetch(12'o1111);
    repeat (100) cycle();
    check("tp5_stall_count", 32'(err_count), 32'd1);
    check("tp5_stall_level", 32'(fifo_level), 32'd1);
    stall = 1'b0;

    base_addr = 12'o300;
    do_reset();
    set_dec(6'b000010, 9'd5, 22'd0);
    cycle();
    check("tp6_code", 32'(err_code), 32'd6);
    check("tp6_count", 32'(err_count), 32'd1);
    check("tp6_first_code", 32'(first_err_code), 32'd6);
    set_dec(6'd0, 9'd0, 22'd0);
    cycle();
    base_addr = START;

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 599) == 0);
      ifu_rd_req  = ($urandom_range(0, 2) == 0);
      ifu_rd_data = 12'($urandom);
      stall       = ($urandom_range(0, 3) == 0);
      base_addr   = ($urandom_range(0, 3) == 0) ? 12'($urandom) : START;
      r = $urandom_range(0, 9);
      if (r < 6) begin
        set_dec(6'd0, 9'd0, 22'd0);
      end else if (r < 9 && q.size() > 0) begin
        w = q[0];
        if (w[11:9] == 3'b111) begin
          o = 22'(1) << $urandom_range(0, 21);
          set_dec(6'd0, 9'd0, o);
        end else begin
          m = 6'(1) << w[11:9];
          set_dec(m, w[8:0], 22'd0);
        end
      end else begin
        case ($urandom_range(0, 2))
          0: begin
            m = 6'(1) << $urandom_range(0, 5);
            set_dec(m, 9'($urandom), 22'd0);
          end
          1: begin
            o = 22'(1) << $urandom_range(0, 21);
            set_dec(6'd0, 9'd0, o);
          end
          default: set_dec(6'($urandom), 9'($urandom), 22'($urandom));
        endcase
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
